// File: rtl/fft_pkg.sv
// fft_pkg: shared constants, complex sample type and bit-reversal helper for the FFT output path.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package fft_pkg;

  localparam int LOG2N_DEF   = 5;
  localparam int DW_DEF      = 16;
  // Widest index the bit-reversal helper handles (largest legal LOG2N).
  localparam int BITREV_MAXW = 10;

  typedef struct packed {
    logic signed [DW_DEF-1:0] re;
    logic signed [DW_DEF-1:0] im;
  } cplx_t;

  // Reverse the low w bits of x; bits at and above w come back as zero.
  function automatic logic [BITREV_MAXW-1:0] bitrev(input logic [BITREV_MAXW-1:0] x,
                                                    input int w);
    logic [BITREV_MAXW-1:0] r;
    r = '0;
    for (int k = 0; k < w; k++) begin
      r[k] = x[w-1-k];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bitrev_bank.sv
// fft_bitrev_bank: one 2^AW-deep register bank, single write port, asynchronous read port.
// Latency: write lands on the next rising edge; read data is combinational from rd_addr_i.
// Backpressure: none; the owner decides when writing is allowed.
module fft_bitrev_bank #(
  parameter int AW = 5,
  parameter int W  = 32
) (
  input  logic          clk,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [W-1:0]  wr_dat_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [W-1:0]  rd_dat_o
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0] mem_q [DEPTH];

  // Sample storage; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_dat_i;
    end
  end

  assign rd_dat_o = mem_q[rd_addr_i];

endmodule

// File: rtl/fft_bitrev_reorder.sv
// fft_bitrev_reorder: ping-pong reorder buffer, bit-reversed (or pass-through) frames in, natural order out.
// Latency: first output valid the cycle after a frame's N-th accepted input; 1 sample/clk sustained.
// Backpressure: in_ready drops while the write bank is full; outputs hold stable while out_ready is low.
// Optional BITREV_LAST_CHK_EN: adds in_last input and sticky frame_err output for frame-alignment checking.
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter int LOG2N = LOG2N_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_bitrev,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_r,
  input  logic signed [DW-1:0] in_i,
`ifdef BITREV_LAST_CHK_EN
  input  logic                 in_last,
  output logic                 frame_err,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_r,
  output logic signed [DW-1:0] out_i,
  output logic [LOG2N-1:0]     out_idx,
  output logic                 out_last
);

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } smp_t;

  localparam logic [LOG2N-1:0] CNT_LAST = '1;

  logic                   wsel_q, wsel_d;
  logic                   rsel_q, rsel_d;
  logic [LOG2N-1:0]       wcnt_q, wcnt_d;
  logic [LOG2N-1:0]       rcnt_q, rcnt_d;
  logic [1:0]             full_q, full_d;
  logic [1:0]             mode_q, mode_d;
  logic                   in_acc, out_hs, frame_mode;
  logic [BITREV_MAXW-1:0] wcnt_ext;
  logic [LOG2N-1:0]       waddr;
  logic [1:0]             bank_we;
  smp_t                   wdat, rdat0, rdat1, rdat;

  assign in_ready  = ~full_q[wsel_q];
  assign in_acc    = in_valid & in_ready;
  assign out_valid = full_q[rsel_q];
  assign out_hs    = out_valid & out_ready;

  // The first beat decides the frame's ordering; later beats reuse the latched mode.
  assign frame_mode = (wcnt_q == '0) ? cfg_bitrev : mode_q[wsel_q];

  // Scatter-write address: bit-reversed arrival index for reorder frames, else arrival index.
  always_comb begin
    wcnt_ext              = '0;
    wcnt_ext[LOG2N-1:0]   = wcnt_q;
    waddr                 = frame_mode ? LOG2N'(bitrev(wcnt_ext, LOG2N)) : wcnt_q;
  end

  assign wdat    = '{re: in_r, im: in_i};
  assign bank_we = {in_acc & wsel_q, in_acc & ~wsel_q};

  fft_bitrev_bank #(.AW(LOG2N), .W($bits(smp_t))) u_bank0 (
    .clk       (clk),
    .wr_en_i   (bank_we[0]),
    .wr_addr_i (waddr),
    .wr_dat_i  (wdat),
    .rd_addr_i (rcnt_q),
    .rd_dat_o  (rdat0)
  );

  fft_bitrev_bank #(.AW(LOG2N), .W($bits(smp_t))) u_bank1 (
    .clk       (clk),
    .wr_en_i   (bank_we[1]),
    .wr_addr_i (waddr),
    .wr_dat_i  (wdat),
    .rd_addr_i (rcnt_q),
    .rd_dat_o  (rdat1)
  );

  assign rdat     = rsel_q ? rdat1 : rdat0;
  assign out_r    = rdat.re;
  assign out_i    = rdat.im;
  assign out_idx  = rcnt_q;
  assign out_last = out_valid & (rcnt_q == CNT_LAST);

  // Pointer and bank-state update; a frame-complete set and a drain-complete clear
  // always target different banks, so both are applied.
  always_comb begin
    wsel_d = wsel_q;
    rsel_d = rsel_q;
    wcnt_d = wcnt_q;
    rcnt_d = rcnt_q;
    full_d = full_q;
    mode_d = mode_q;
    if (in_acc) begin
      wcnt_d = wcnt_q + LOG2N'(1);
      if (wcnt_q == '0) begin
        mode_d[wsel_q] = cfg_bitrev;
      end
      if (wcnt_q == CNT_LAST) begin
        full_d[wsel_q] = 1'b1;
        wsel_d         = ~wsel_q;
      end
    end
    if (out_hs) begin
      rcnt_d = rcnt_q + LOG2N'(1);
      if (rcnt_q == CNT_LAST) begin
        full_d[rsel_q] = 1'b0;
        rsel_d         = ~rsel_q;
      end
    end
  end

  // State registers with synchronous active-low reset; reset discards any buffered frames.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wsel_q <= 1'b0;
      rsel_q <= 1'b0;
      wcnt_q <= '0;
      rcnt_q <= '0;
      full_q <= 2'b00;
      mode_q <= 2'b00;
    end else begin
      wsel_q <= wsel_d;
      rsel_q <= rsel_d;
      wcnt_q <= wcnt_d;
      rcnt_q <= rcnt_d;
      full_q <= full_d;
      mode_q <= mode_d;
    end
  end

`ifdef BITREV_LAST_CHK_EN
  logic frame_err_q, frame_err_d;

  // Sticky flag: in_last must coincide exactly with the N-th beat of the counted frame.
  always_comb begin
    frame_err_d = frame_err_q | (in_acc & (in_last != (wcnt_q == CNT_LAST)));
  end

  // Frame-alignment error register; only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= frame_err_d;
    end
  end

  assign frame_err = frame_err_q;
`endif

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// tb_fft_bitrev_reorder: directed, table-driven bench for the bit-reversal reorder buffer (LOG2N=5, DW=16).
// Latency: checks first-output timing, gapless streaming and in_ready recovery timing.
// Backpressure: exercises stalled consumer with both banks full.
`timescale 1ns/1ps
module tb_fft_bitrev_reorder;

  localparam int LN = 5;
  localparam int N  = 32;
  localparam int W  = 16;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                cfg_bitrev = 1'b0;
  logic                in_valid = 1'b0;
  logic                out_ready = 1'b0;
  logic signed [W-1:0] in_r = '0;
  logic signed [W-1:0] in_i = '0;
  logic signed [W-1:0] out_r, out_i;
  logic                in_ready, out_valid, out_last;
  logic [LN-1:0]       out_idx;
`ifdef BITREV_LAST_CHK_EN
  logic                in_last = 1'b0;
  logic                frame_err;
`endif

  fft_bitrev_reorder #(.LOG2N(LN), .DW(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_bitrev (cfg_bitrev),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_r       (in_r),
    .in_i       (in_i),
`ifdef BITREV_LAST_CHK_EN
    .in_last    (in_last),
    .frame_err  (frame_err),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_r      (out_r),
    .out_i      (out_i),
    .out_idx    (out_idx),
    .out_last   (out_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output capture: one record per completed handshake.
  int cap_r[$];
  int cap_i[$];
  int cap_idx[$];
  int cap_last[$];
  int cap_cyc[$];
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      cap_r.push_back(int'(out_r));
      cap_i.push_back(int'(out_i));
      cap_idx.push_back(int'(out_idx));
      cap_last.push_back(int'(out_last));
      cap_cyc.push_back(cyc);
    end
  end

  int vec_cnt = 0;
  int err_cnt = 0;
  int stalls = 0;
  int last_acc_cyc = 0;

  typedef struct {
    int j;
    int exp_r;
    int exp_idx;
    bit exp_last;
  } vec_t;
  vec_t spot[11];

  task automatic chk(input string name, input int act, input int exp);
    vec_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Independent 5-bit reversal: shift bits out LSB-first into a new MSB-first word.
  function automatic int brv(input int x);
    int r = 0;
    for (int b = 0; b < LN; b++) r = (r << 1) | ((x >> b) & 1);
    return r;
  endfunction

  // Present one beat at posedge+1 and return once it has been accepted.
  task automatic send_beat(input logic cfg, input int v, input logic last);
    int t = 0;
    cfg_bitrev = cfg;
    in_r       = W'(v);
    in_i       = W'(-v);
    in_valid   = 1'b1;
`ifdef BITREV_LAST_CHK_EN
    in_last    = last;
`else
    if (last) t = 0;
`endif
    @(negedge clk);
    if (!in_ready) stalls++;
    while (!in_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    last_acc_cyc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input int base, input logic cfg0, input bit toggle);
    logic c;
    for (int k = 0; k < N; k++) begin
      c = cfg0;
      if (k != 0 && toggle && (k % 2 == 1)) c = ~cfg0;
      send_beat(c, base + k, k == N - 1);
    end
  endtask

  task automatic wait_caps(input int n);
    int t = 0;
    while (cap_r.size() < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("capture_count", cap_r.size(), n);
  endtask

  task automatic check_frame(input string tag, input int b, input int base, input bit mode);
    int e;
    for (int j = 0; j < N; j++) begin
      e = mode ? base + brv(j) : base + j;
      chk({tag, "_r"}, cap_r[b + j], e);
      chk({tag, "_i"}, cap_i[b + j], -e);
      chk({tag, "_idx"}, cap_idx[b + j], j);
      chk({tag, "_last"}, cap_last[b + j], (j == N - 1) ? 1 : 0);
    end
  endtask

  initial begin
    int b;
    int r0, i0;
    int early;

    // Hand-computed bitrev5 spot values for frame with r=k on beat k.
    spot = '{'{0, 0, 0, 1'b0}, '{1, 16, 1, 1'b0}, '{2, 8, 2, 1'b0}, '{3, 24, 3, 1'b0},
             '{4, 4, 4, 1'b0}, '{5, 20, 5, 1'b0}, '{6, 12, 6, 1'b0}, '{7, 28, 7, 1'b0},
             '{16, 1, 16, 1'b0}, '{30, 15, 30, 1'b0}, '{31, 31, 31, 1'b1}};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_idx", int'(out_idx), 0);
    chk("rst_out_last", int'(out_last), 0);
    @(posedge clk);
    #1 rst = 1'b1;

    // 1: single bit-reversed frame
    out_ready = 1'b1;
    b = cap_r.size();
    send_frame(0, 1'b1, 1'b0);
    wait_caps(b + N);
    chk("t1_first_valid_cycle", cap_cyc[b], last_acc_cyc);
    for (int v = 0; v < 11; v++) begin
      chk("t1_spot_r", cap_r[b + spot[v].j], spot[v].exp_r);
      chk("t1_spot_i", cap_i[b + spot[v].j], -spot[v].exp_r);
      chk("t1_spot_idx", cap_idx[b + spot[v].j], spot[v].exp_idx);
      chk("t1_spot_last", cap_last[b + spot[v].j], int'(spot[v].exp_last));
    end
    check_frame("t1", b, 0, 1'b1);

    // 2: three back-to-back frames, no stalls, no output gaps
    repeat (3) @(posedge clk);
    #1;
    b = cap_r.size();
    stalls = 0;
    send_frame(0, 1'b1, 1'b0);
    send_frame(32, 1'b1, 1'b0);
    send_frame(64, 1'b1, 1'b0);
    wait_caps(b + 3 * N);
    chk("t2_in_ready_stalls", stalls, 0);
    chk("t2_gapless_span", cap_cyc[b + 3 * N - 1] - cap_cyc[b], 3 * N - 1);
    check_frame("t2_f0", b, 0, 1'b1);
    check_frame("t2_f1", b + N, 32, 1'b1);
    check_frame("t2_f2", b + 2 * N, 64, 1'b1);

    // 3: consumer stalled for two frames
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b0;
    b = cap_r.size();
    send_frame(100, 1'b1, 1'b0);
    send_frame(200, 1'b1, 1'b0);
    @(negedge clk);
    chk("t3_in_ready_full", int'(in_ready), 0);
    chk("t3_out_valid", int'(out_valid), 1);
    chk("t3_out_idx0", int'(out_idx), 0);
    chk("t3_out_r0", int'(out_r), 100);
    r0 = int'(out_r);
    i0 = int'(out_i);
    repeat (4) @(negedge clk);
    chk("t3_stall_valid", int'(out_valid), 1);
    chk("t3_stall_r", int'(out_r), r0);
    chk("t3_stall_i", int'(out_i), i0);
    chk("t3_stall_idx", int'(out_idx), 0);
    chk("t3_stall_in_ready", int'(in_ready), 0);
    @(posedge clk);
    #1 out_ready = 1'b1;
    early = 0;
    for (int h = 0; h < N; h++) begin
      @(negedge clk);
      if (in_ready) early++;
    end
    chk("t3_in_ready_early", early, 0);
    @(negedge clk);
    chk("t3_in_ready_recover", int'(in_ready), 1);
    wait_caps(b + 2 * N);
    check_frame("t3_f0", b, 100, 1'b1);
    check_frame("t3_f1", b + N, 200, 1'b1);

    // 4: natural-order frame then bit-reversed frame, cfg toggling mid-frame
    repeat (3) @(posedge clk);
    #1;
    b = cap_r.size();
    send_frame(0, 1'b0, 1'b1);
    send_frame(500, 1'b1, 1'b1);
    wait_caps(b + 2 * N);
    check_frame("t4_f0", b, 0, 1'b0);
    check_frame("t4_f1", b + N, 500, 1'b1);

    // 5: reset after 10 accepts, then a clean frame
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 10; k++) send_beat(1'b0, 900 + k, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("t5_out_valid", int'(out_valid), 0);
    chk("t5_in_ready", int'(in_ready), 1);
    chk("t5_out_idx", int'(out_idx), 0);
    @(posedge clk);
    #1;
    b = cap_r.size();
    send_frame(700, 1'b1, 1'b0);
    wait_caps(b + N);
    check_frame("t5", b, 700, 1'b1);

`ifdef BITREV_LAST_CHK_EN
    // 6: in_last on the wrong beat
    chk("t6_err_clear", int'(frame_err), 0);
    b = cap_r.size();
    for (int k = 0; k < N - 1; k++) send_beat(1'b1, 300 + k, k == 30);
    @(negedge clk);
    chk("t6_err_set", int'(frame_err), 1);
    send_beat(1'b1, 300 + N - 1, 1'b0);
    wait_caps(b + N);
    repeat (5) @(negedge clk);
    chk("t6_err_sticky", int'(frame_err), 1);
    chk("t6_out_count", cap_r.size() - b, N);
    check_frame("t6", b, 300, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/fft_bitrev_reorder.md
Name: fft_bitrev_reorder

Overview:
Parametrised streaming bit-reversal reorder buffer for the radix-2 FFT output path. It replaces the fixed 32-point sorter.
- Accepts N = 2^LOG2N complex samples per frame in bit-reversed order and emits them in natural order.
- Uses ping-pong double buffering, so back-to-back frames stream without stalls.
- Sits between the last butterfly stage and the result consumer. Valid/ready on both sides.

Parameters:
LOG2N, 5, log2 of FFT points per frame; N = 2^LOG2N, legal range 2..10
DW, 16, signed width of each real and imaginary component

Ports:
clk  input  1  single clock; all logic on rising edge
rst  input  1  synchronous active-low reset, sampled on rising clk
cfg_bitrev  input  1  1 = reorder frame, 0 = pass frame in arrival order; sampled on first beat of each frame
in_valid  input  1  input sample valid
in_ready  output  1  buffer can accept sample
in_r  input  DW  signed real part
in_i  input  DW  signed imaginary part
out_valid  output  1  output sample valid
out_ready  input  1  consumer accepts sample
out_r  output  DW  signed real part, natural order
out_i  output  DW  signed imaginary part, natural order
out_idx  output  LOG2N  natural-order bin index of current output
out_last  output  1  high on bin N-1

Behaviour:
Interface:
- One clock, clk.
- Reset rst is synchronous and active-low.

Storage and pointers:
- Two banks, each N x 2DW, selected by wsel and rsel.
- Per-bank state: full[b], mode[b].
- Write counter wcnt and read counter rcnt, each LOG2N bits.

Write side:
- in_ready = ~full[wsel].
- Input accept = in_valid & in_ready.
- On accept, store the sample at address bitrev(wcnt) if the frame mode is 1, else at wcnt.
  - Frame mode = cfg_bitrev when wcnt==0, else mode[wsel].
- wcnt==0 accept latches mode[wsel] = cfg_bitrev.
- wcnt==N-1 accept: set full[wsel], toggle wsel, wcnt wraps to 0.

Read side:
- out_valid = full[rsel].
- Output data is combinational from bank[rsel][rcnt].
- out_idx = rcnt; out_last = out_valid & (rcnt==N-1).
- On out_valid & out_ready, rcnt increments.
- At rcnt==N-1: clear full[rsel], toggle rsel, rcnt wraps to 0.

Latency and throughput:
- First output is valid the cycle after the N-th input accept.
- Sustained throughput is 1 sample/clk with out_ready held high.

Boundary cases:
- Writer and reader can never target the same non-full/full bank conflict: the writer only writes banks with full=0, the reader only reads banks with full=1.
- A set and a clear in the same cycle always hit different banks. Both take effect.
- Both banks full: in_ready=0 until the reader finishes a frame.
  - in_ready rises the cycle after the final output handshake.
- Holding out_ready low freezes all outputs stable. Valid must not drop.
- Reset mid-frame discards all data in both banks.

Reset values (rst=0):
- wsel=rsel=0, wcnt=rcnt=0, full=2'b00, mode=2'b00.
- out_valid=0, out_last=0, out_idx=0, in_ready=1 from the next cycle.
- Memory contents are not reset; out_r/out_i are don't-care while out_valid=0.

Arithmetic:
- bitrev(x)[k] = x[LOG2N-1-k].
- Data passes through unmodified. No scaling, no sign change.

Optional Feature:
Macro BITREV_LAST_CHK_EN adds frame-alignment checking.

With the macro defined:
- Adds input port in_last (1 bit) and output frame_err (1 bit, sticky).
- On an input accept, frame_err sets if in_last != (wcnt==N-1).
- The frame still completes by count; the error does not resync.
- frame_err clears only on reset; reset value 0.

Without the macro:
- Neither port exists and no check logic is built.

Decomposition:
Package fft_pkg holds:
- the default LOG2N and DW constants;
- a typedef for the complex sample struct {re, im};
- a bitrev function parametrised by width.

Sub-module fft_bitrev_bank is the natural split:
- one N-deep register bank;
- write port with address and enable;
- asynchronous read port.

Two instances are selected by wsel/rsel.

Test Plan:
All cases use LOG2N=5, DW=16.
1. Single frame, cfg_bitrev=1: input beat k carries r=k, i=-k; out_ready=1 -> 32 outputs with out_r=bitrev5(j), e.g. j=1 -> r=16, i=-16; j=2 -> r=8; j=31 -> r=31. out_last only on j=31. First out_valid the cycle after beat 31.
2. Three back-to-back frames, in_valid and out_ready high continuously -> in_ready never drops. 96 outputs total, each frame correctly reordered, no gap between frames after the first.
3. Backpressure: out_ready low for the first two frames -> in_ready=0 after 64 accepts. Raising out_ready -> in_ready returns the cycle after output 31 of frame 0; outputs stay stable while stalled.
4. Frame 0 with cfg_bitrev=0 and frame 1 with cfg_bitrev=1, where cfg_bitrev toggles mid-frame -> frame 0 output r=0..31 in order, frame 1 bit-reversed. Mid-frame cfg changes are ignored.
5. Reset asserted after 10 input accepts -> next cycle out_valid=0 and in_ready=1. A fresh frame then outputs correctly from idx 0.
6. (BITREV_LAST_CHK_EN) in_last pulsed on beat 30 -> frame_err=1 the next cycle and stays 1. The frame still outputs 32 samples.
